// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the data cache (D side)
// and the instruction cache (I side).
//
// Ports:
//   CLK, RESET              clock; synchronous active-low reset
//   D_READ/D_WRITE          data-cache block read / write-back request
//   D_ADDRESS/D_WRITEDATA   data-cache block address / write-back block
//   D_READDATA/D_BUSYWAIT   registered block to data cache / data-side stall
//   I_READ/I_ADDRESS        instruction-cache block read request / address
//   I_READDATA/I_BUSYWAIT   registered block to instr cache / instr-side stall
//   M_READ/M_WRITE          registered memory strobes
//   M_ADDRESS/M_WRITEDATA   registered memory address / write block
//   M_READDATA/M_BUSYWAIT   memory read block / memory busy
//
// One side is granted at a time; ties alternate (round-robin) and D wins the
// first tie after reset. Each transaction ends with a one-cycle RELEASE with
// strobes low, during which the winner's busywait drops.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, RELEASE} state_t;

    state_t state, state_nxt;
    logic   dreq, ireq;
    logic   d_done, i_done;
    logic   last_i;     // 1: I side held the most recent grant
    logic   started;    // masks the cycle before memory raises busywait
    logic   pick_d;
    logic   complete;

    assign dreq = D_READ | D_WRITE;
    assign ireq = I_READ;

    assign D_BUSYWAIT = dreq & ~d_done;
    assign I_BUSYWAIT = ireq & ~i_done;

    // D wins when alone, or on a tie when I was granted last.
    assign pick_d = dreq & (~ireq | last_i);

    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (dreq | ireq) state_nxt = pick_d ? GRANT_D : GRANT_I;
            end
            GRANT_D, GRANT_I: begin
                if (started && !M_BUSYWAIT) begin
                    complete  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= '0;
            D_READDATA  <= '0;
            I_READDATA  <= '0;
            last_i      <= 1'b1;
            started     <= 1'b0;
            d_done      <= 1'b0;
            i_done      <= 1'b0;
        end else begin
            // done flags are single-cycle pulses covering the RELEASE cycle
            d_done <= 1'b0;
            i_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dreq | ireq) begin
                        started <= 1'b0;
                        if (pick_d) begin
                            M_ADDRESS   <= D_ADDRESS;
                            M_WRITEDATA <= D_WRITEDATA;
                            // read+write together is a write-back
                            M_WRITE     <= D_WRITE;
                            M_READ      <= ~D_WRITE;
                            last_i      <= 1'b0;
                        end else begin
                            M_ADDRESS   <= I_ADDRESS;
                            M_READ      <= 1'b1;
                            M_WRITE     <= 1'b0;
                            last_i      <= 1'b1;
                        end
                    end
                end
                GRANT_D, GRANT_I: begin
                    if (!started) started <= 1'b1;
                    if (complete) begin
                        M_READ  <= 1'b0;
                        M_WRITE <= 1'b0;
                        if (state == GRANT_D) begin
                            d_done <= 1'b1;
                            if (M_READ) D_READDATA <= M_READDATA;
                        end else begin
                            i_done <= 1'b1;
                            if (M_READ) I_READDATA <= M_READDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
